// File: rtl/snap_intc_pkg.sv
// Shared definitions for the global kernel-completion interrupt controller:
// register map, default read pattern, FSM states and a byte-strobe helper.
package snap_intc_pkg;

    localparam logic [31:0] REG_ACTION_TYPE = 32'h0000_0010;
    localparam logic [31:0] REG_STATUS      = 32'h0000_0030;
    localparam logic [31:0] REG_ENABLE      = 32'h0000_0034;
    localparam logic [31:0] REG_ACTIVE      = 32'h0000_0038;
    localparam logic [31:0] REG_HOLDOFF     = 32'h0000_003C;
    localparam logic [31:0] REG_IRQ_COUNT   = 32'h0000_0040;

    localparam logic [31:0] DEFAULT_RDATA   = 32'h5A5A_A5A5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_CLR,
        ST_HOLD
    } intc_state_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/intc_status_bank.sv
// Per-kernel rising-edge detect feeding a write-1-to-clear STATUS register.
// A new event in the same cycle as a clear of that bit keeps the bit set.
module intc_status_bank #(
    parameter int KERNEL_NUM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KERNEL_NUM-1:0] kernel_complete_i,
    input  logic                  clr_en_i,
    input  logic [KERNEL_NUM-1:0] clr_mask_i,
    output logic [KERNEL_NUM-1:0] status_o
);

    logic [KERNEL_NUM-1:0] hist_q;
    logic [KERNEL_NUM-1:0] status_q, status_d;
    logic [KERNEL_NUM-1:0] rise;

    assign rise = kernel_complete_i & ~hist_q;

    always_comb begin
        status_d = status_q;
        if (clr_en_i)
            status_d = status_d & ~clr_mask_i;
        status_d = status_d | rise;
    end

    // History starts at all ones so levels already high at reset release are not events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q   <= '1;
            status_q <= '0;
        end else begin
            hist_q   <= kernel_complete_i;
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/axi_lite_global_intc.sv
// AXI-Lite register slave plus interrupt FSM aggregating kernel completions
// into one registered interrupt with ack, clear and programmable hold-off.
module axi_lite_global_intc
    import snap_intc_pkg::*;
#(
    parameter int KERNEL_NUM    = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int HOLDOFF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    input  logic [31:0]           i_action_type,
    input  logic [KERNEL_NUM-1:0] kernel_complete,
    output logic                  o_interrupt,
    input  logic                  i_interrupt_ack
);

    logic                     awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [ADDR_WIDTH-1:0]    awaddr_q;
    logic [31:0]              wdata_q, wmask, rdata_q, rd_mux;
    logic [3:0]               wstrb_q;
    logic                     wr_en;
    logic [KERNEL_NUM-1:0]    enable_q, enable_d, status, active;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d, cnt_q;
    logic [31:0]              irq_count_q;
    logic                     irq_q;
    intc_state_e              state_q;
    logic                     unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // Both beats captured and no response outstanding: commit exactly once.
    assign wr_en  = ~awready_q & ~wready_q & ~bvalid_q;
    assign wmask  = strb_mask(wstrb_q);
    assign active = status & enable_q;

    intc_status_bank #(.KERNEL_NUM(KERNEL_NUM)) u_status (
        .clk               (clk),
        .rst_n             (rst_n),
        .kernel_complete_i (kernel_complete),
        .clr_en_i          (wr_en && awaddr_q == ADDR_WIDTH'(REG_STATUS)),
        .clr_mask_i        (KERNEL_NUM'(wdata_q & wmask)),
        .status_o          (status)
    );

    always_comb begin
        enable_d  = enable_q;
        holdoff_d = holdoff_q;
        if (wr_en && awaddr_q == ADDR_WIDTH'(REG_ENABLE))
            enable_d = KERNEL_NUM'((32'(enable_q) & ~wmask) | (wdata_q & wmask));
        if (wr_en && awaddr_q == ADDR_WIDTH'(REG_HOLDOFF))
            holdoff_d = HOLDOFF_WIDTH'((32'(holdoff_q) & ~wmask) | (wdata_q & wmask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            enable_q  <= '1;
            holdoff_q <= '0;
        end else begin
            enable_q  <= enable_d;
            holdoff_q <= holdoff_d;
            if (s_axi_awvalid && awready_q) begin
                awready_q <= 1'b0;
                awaddr_q  <= s_axi_awaddr;
            end
            if (s_axi_wvalid && wready_q) begin
                wready_q <= 1'b0;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end
            if (wr_en)
                bvalid_q <= 1'b1;
            if (bvalid_q && s_axi_bready) begin
                bvalid_q  <= 1'b0;
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = DEFAULT_RDATA;
        if (s_axi_araddr == ADDR_WIDTH'(REG_ACTION_TYPE))    rd_mux = i_action_type;
        else if (s_axi_araddr == ADDR_WIDTH'(REG_STATUS))    rd_mux = 32'(status);
        else if (s_axi_araddr == ADDR_WIDTH'(REG_ENABLE))    rd_mux = 32'(enable_q);
        else if (s_axi_araddr == ADDR_WIDTH'(REG_ACTIVE))    rd_mux = 32'(active);
        else if (s_axi_araddr == ADDR_WIDTH'(REG_HOLDOFF))   rd_mux = 32'(holdoff_q);
        else if (s_axi_araddr == ADDR_WIDTH'(REG_IRQ_COUNT)) rd_mux = irq_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
        end
    end

    // The interrupt is raised one cycle after ASSERT entry; IRQ_COUNT tracks its rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
            irq_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE:
                    if (active != '0 && cnt_q == '0)
                        state_q <= ST_ASSERT;
                ST_ASSERT:
                    if (i_interrupt_ack) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_WAIT_CLR;
                    end else begin
                        irq_q <= 1'b1;
                        if (!irq_q)
                            irq_count_q <= irq_count_q + 32'd1;
                    end
                ST_WAIT_CLR:
                    if (active == '0) begin
                        if (holdoff_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= holdoff_q;
                            state_q <= ST_HOLD;
                        end
                    end
                ST_HOLD:
                    if (cnt_q == '0)
                        state_q <= ST_IDLE;
                    else
                        cnt_q <= cnt_q - HOLDOFF_WIDTH'(1);
                default:
                    state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign o_interrupt   = irq_q;

endmodule

// File: tb/tb_axi_lite_global_intc.sv
// Directed bench: stimulus pushes expected read/write responses into queues,
// a negedge monitor pops and compares whenever a response handshakes.
module tb_axi_lite_global_intc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic [31:0] i_action_type;
    logic [7:0]  kernel_complete;
    logic        o_interrupt;
    logic        i_interrupt_ack;

    always #5 clk = ~clk;

    axi_lite_global_intc dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .i_action_type(i_action_type), .kernel_complete(kernel_complete),
        .o_interrupt(o_interrupt), .i_interrupt_ack(i_interrupt_ack)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] b_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         t0, t1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no DUT response within cycle budget", name);
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        logic [1:0] eb;
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            if (rd_q.size() == 0) timeout("rd_unexpected");
            else begin
                e = rd_q.pop_front();
                check(e.name, s_axi_rdata, e.data);
                check({e.name, "_rresp"}, 32'(s_axi_rresp), 32'(2'b00));
            end
        end
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) timeout("b_unexpected");
            else begin
                eb = b_q.pop_front();
                check("bresp", 32'(s_axi_bresp), 32'(eb));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int kick);
        for (int i = 0; i < 20 && !(s_axi_awready && s_axi_wready); i++) tick(1);
        if (!(s_axi_awready && s_axi_wready)) timeout("wr_ready");
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = data; s_axi_wstrb = strb;
        b_q.push_back(2'b00);
        tick(1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (kick >= 0) kernel_complete[kick] = 1'b1;
        for (int i = 0; i < 20 && !s_axi_bvalid; i++) tick(1);
        if (!s_axi_bvalid) timeout("wr_bvalid");
        tick(1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        for (int i = 0; i < 20 && !s_axi_arready; i++) tick(1);
        if (!s_axi_arready) timeout("rd_ready");
        s_axi_arvalid = 1'b1; s_axi_araddr = addr;
        e.name = name; e.data = exp;
        rd_q.push_back(e);
        tick(1);
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 20 && s_axi_rvalid; i++) tick(1);
        if (s_axi_rvalid) timeout("rd_rvalid");
    endtask

    task automatic ack();
        i_interrupt_ack = 1'b1;
        tick(1);
        i_interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input int lim, input string name, output int t);
        for (int i = 0; i < lim && !o_interrupt; i++) tick(1);
        if (!o_interrupt) timeout(name);
        t = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awprot = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        s_axi_bready = 1; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arprot = 0;
        s_axi_rready = 1; i_action_type = 32'hC0DE_0042;
        kernel_complete = 8'h80;  // kernel 7 high across reset release: no event
        i_interrupt_ack = 0;
        tick(3);
        rst_n = 1'b1;
        check("rst_awready", 32'(s_axi_awready), 1);
        check("rst_wready",  32'(s_axi_wready),  1);
        check("rst_arready", 32'(s_axi_arready), 1);
        check("rst_bvalid",  32'(s_axi_bvalid),  0);
        check("rst_rvalid",  32'(s_axi_rvalid),  0);
        check("rst_rdata",   s_axi_rdata,        0);
        check("rst_irq",     32'(o_interrupt),   0);
        tick(3);
        check("no_event_at_release", 32'(o_interrupt), 0);
        axi_read(32'h30, 32'h0,  "rst_status");
        axi_read(32'h34, 32'hFF, "rst_enable");
        axi_read(32'h3C, 32'h0,  "rst_holdoff");
        axi_read(32'h40, 32'h0,  "rst_irq_count");
        axi_read(32'h10, 32'hC0DE_0042, "action_type");
        axi_write(32'h10, 32'h0, 4'hF, -1);
        axi_read(32'h10, 32'hC0DE_0042, "action_type_ro");
        axi_write(32'h40, 32'hFFFF, 4'hF, -1);
        axi_read(32'h40, 32'h0, "irq_count_ro");

        // event -> interrupt, two cycles after ACTIVE
        kernel_complete[3] = 1'b1;
        tick(2);
        check("irq_early", 32'(o_interrupt), 0);
        tick(1);
        check("irq_latency", 32'(o_interrupt), 1);
        axi_read(32'h30, 32'h08, "evt_status");
        axi_read(32'h38, 32'h08, "evt_active");
        axi_read(32'h40, 32'd1,  "evt_irq_count");

        // ack and clear
        ack();
        check("irq_drop_on_ack", 32'(o_interrupt), 0);
        axi_write(32'h30, 32'h08, 4'hF, -1);
        kernel_complete[3] = 1'b0;
        tick(5);
        check("no_reassert", 32'(o_interrupt), 0);
        axi_read(32'h30, 32'h0, "clr_status");
        axi_read(32'h40, 32'd1, "clr_irq_count");

        // masked source
        axi_write(32'h34, 32'hFE, 4'hF, -1);
        kernel_complete[0] = 1'b1;
        tick(5);
        check("masked_irq", 32'(o_interrupt), 0);
        axi_read(32'h30, 32'h01, "mask_status");
        axi_read(32'h38, 32'h00, "mask_active");
        axi_write(32'h34, 32'h00, 4'h0, -1);
        axi_read(32'h34, 32'hFE, "enable_strb0");
        axi_write(32'h34, 32'hFF, 4'hF, -1);
        wait_irq(10, "unmask_irq", t1);
        axi_read(32'h40, 32'd2, "unmask_irq_count");
        ack();
        axi_write(32'h30, 32'h01, 4'hF, -1);
        kernel_complete[0] = 1'b0;
        tick(3);

        // hold-off: second event during WAIT_CLR, then ACTIVE cleared via ENABLE
        axi_write(32'h3C, 32'd10, 4'hF, -1);
        axi_read(32'h3C, 32'd10, "holdoff_rb");
        kernel_complete[1] = 1'b1;
        wait_irq(10, "hold_irq1", t1);
        ack();
        kernel_complete[2] = 1'b1;
        tick(2);
        axi_read(32'h30, 32'h06, "hold_status");
        axi_write(32'h34, 32'h00, 4'hF, -1);
        t0 = cyc - 1;  // ACTIVE became zero after this edge
        axi_write(32'h34, 32'hFF, 4'hF, -1);
        wait_irq(50, "hold_irq2", t1);
        n_cmp++;
        if (t1 - t0 < 10) begin
            n_bad++;
            $display("FAIL holdoff_gap: got %0d cycles required at least 10", t1 - t0);
        end
        axi_read(32'h40, 32'd4, "hold_irq_count");
        ack();
        axi_write(32'h30, 32'h06, 4'hF, -1);
        kernel_complete[2:1] = 2'b00;
        axi_write(32'h3C, 32'd0, 4'hF, -1);
        tick(15);
        check("hold_no_reassert", 32'(o_interrupt), 0);

        // set and clear of the same STATUS bit in one cycle
        axi_write(32'h34, 32'h00, 4'hF, -1);
        kernel_complete[5] = 1'b1;
        tick(2);
        kernel_complete[5] = 1'b0;
        tick(2);
        axi_read(32'h30, 32'h20, "pre_set_status");
        axi_write(32'h30, 32'h20, 4'hF, 5);
        axi_read(32'h30, 32'h20, "set_wins");
        kernel_complete[5] = 1'b0;
        axi_write(32'h30, 32'h20, 4'hE, -1);
        axi_read(32'h30, 32'h20, "w1c_strb_masked");
        axi_write(32'h30, 32'h20, 4'h1, -1);
        axi_read(32'h30, 32'h00, "w1c_strb_byte0");
        check("disabled_irq", 32'(o_interrupt), 0);

        // W before AW, bready stalled
        s_axi_bready = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_3377; s_axi_wstrb = 4'h1;
        tick(1);
        s_axi_wvalid = 1'b0;
        check("w_first_wready", 32'(s_axi_wready), 0);
        check("w_first_awready", 32'(s_axi_awready), 1);
        tick(1);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h3C;
        b_q.push_back(2'b00);
        tick(1);
        s_axi_awvalid = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("bvalid_held", 32'(s_axi_bvalid), 1);
            check("bresp_held", 32'(s_axi_bresp), 0);
            tick(1);
        end
        s_axi_bready = 1'b1;
        tick(1);
        check("bvalid_after_b", 32'(s_axi_bvalid), 0);
        check("readys_after_b", 32'({s_axi_awready, s_axi_wready}), 32'h3);
        axi_read(32'h3C, 32'h77, "holdoff_byte0");
        axi_read(32'h44, 32'h5A5A_A5A5, "unmapped_read");
        axi_read(32'h40, 32'd4, "final_irq_count");

        tick(3);
        if (rd_q.size() != 0 || b_q.size() != 0) timeout("pending_responses");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
